// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer and synchronous flush.
// The main register drives the outputs and the skid register catches one
// extra entry. This keeps in_ready independent of out_ready.
// Bubbles (out_valid=0) always carry an all-zero control field.
module pipe_stage_skid #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // State encoding equals the number of held entries.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              acc_s;
  logic              con_s;

  // State register; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush squashes to EMPTY ahead of accept/consume.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_s) state_d = ST_ONE;
          else       state_d = ST_EMPTY;
        end
        ST_ONE: begin
          if (acc_s && !con_s)      state_d = ST_FULL;
          else if (!acc_s && con_s) state_d = ST_EMPTY;
          else                      state_d = ST_ONE;
        end
        ST_FULL: begin
          if (con_s) state_d = ST_ONE;
          else       state_d = ST_FULL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Outputs and handshake qualifiers; everything except in_ready comes from registers.
  always_comb begin
    in_ready  = (state_q != ST_FULL) & ~flush;
    out_valid = (state_q != ST_EMPTY);
    occupancy = state_q;
    out_ctrl  = main_ctrl_q;
    out_data  = main_data_q;
    acc_s     = in_valid & in_ready;
    con_s     = out_valid & out_ready;
  end

  // Datapath next values; main_ctrl is zeroed whenever the stage drains or flushes.
  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_s) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else begin
            main_ctrl_d = '0;
          end
        end
        ST_ONE: begin
          if (acc_s && con_s) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (acc_s) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (con_s) begin
            main_ctrl_d = '0;
          end else begin
            main_ctrl_d = main_ctrl_q;
          end
        end
        ST_FULL: begin
          if (con_s) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            skid_data_d = '0;
          end else begin
            skid_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
          skid_data_d = '0;
        end
      endcase
    end
  end

  // Datapath registers; reset clears data too, unlike flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule
